// File: rtl/ccff_loader.sv
// ccff_loader
// Streams a word-wide bitstream, preceded by a sentinel pattern, MSB first into
// the head of a configuration flip-flop chain. The sentinel must come back out
// of the chain tail exactly CHAIN_LEN shifts later. That proves the chain has
// the expected length and is unbroken.
module ccff_loader #(
    parameter int                CHAIN_LEN = 32,
    parameter int                WORD_W    = 8,
    parameter int                SENT_W    = 8,
    parameter logic [SENT_W-1:0] SENTINEL  = 8'hA5
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Derived sizes
    localparam int TOTAL     = CHAIN_LEN + SENT_W;
    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
    localparam int SH_W      = (WORD_W > SENT_W) ? WORD_W : SENT_W;
    localparam int NW        = $clog2(TOTAL + 1);
    localparam int CW        = $clog2(SH_W + 1);
    localparam int WCW       = $clog2(NWORDS + 1);

    localparam logic [NW-1:0]   N_ZERO     = {NW{1'b0}};
    localparam logic [NW-1:0]   N_LAST     = NW'(TOTAL - 1);
    localparam logic [NW-1:0]   N_CHECK    = NW'(CHAIN_LEN);
    localparam logic [WCW-1:0]  W_ZERO     = {WCW{1'b0}};
    localparam logic [WCW-1:0]  WORDS_REQ  = WCW'(NWORDS);
    localparam logic [WCW-1:0]  WORD_LAST  = WCW'(NWORDS - 1);
    localparam logic [CW-1:0]   CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_SENT   = CW'(SENT_W - 1);
    localparam logic [CW-1:0]   CNT_WORD   = CW'(WORD_W - 1);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(LAST_BITS - 1);
    // Sentinel left-aligned in the shifter so its MSB sits at the shift-out end
    localparam logic [SH_W-1:0] SENT_AL    = SH_W'(SENTINEL) << (SH_W - SENT_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic [1:0]        state_r,     state_s;
    logic [NW-1:0]     n_r,         n_s;          // enabled shift edges so far
    logic [SH_W-1:0]   shreg_r,     shreg_s;      // bits not yet presented, MSB first
    logic [CW-1:0]     sh_cnt_r,    sh_cnt_s;     // valid bits left in shreg
    logic [SENT_W-1:0] chk_r,       chk_s;        // sentinel bits still expected at tail
    logic [WORD_W-1:0] hold_r,      hold_s;       // prefetched word
    logic              hold_full_r, hold_full_s;
    logic [WCW-1:0]    words_acc_r, words_acc_s;  // words taken over the handshake
    logic [WCW-1:0]    words_ld_r,  words_ld_s;   // words moved into the shifter
    logic              head_r,      head_s;
    logic              shift_en_r,  shift_en_s;
    logic              ready_r,     ready_s;
    logic              busy_r,      busy_s;
    logic              done_r,      done_s;
    logic              error_r,     error_s;
    logic [SH_W-1:0]   word_al_s;
    logic              finish_s;

    // Next-state logic: start handling, per-edge shift/tail check, and refill of the next bit
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        shreg_s     = shreg_r;
        sh_cnt_s    = sh_cnt_r;
        chk_s       = chk_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        words_acc_s = words_acc_r;
        words_ld_s  = words_ld_r;
        head_s      = head_r;
        shift_en_s  = shift_en_r;
        done_s      = done_r;
        error_s     = error_r;
        word_al_s   = SH_W'(hold_r) << (SH_W - WORD_W);
        finish_s    = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    // First sentinel bit goes straight to the head; the rest wait in the shifter
                    state_s     = ST_SHIFT;
                    done_s      = 1'b0;
                    error_s     = 1'b0;
                    n_s         = N_ZERO;
                    shreg_s     = SENT_AL << 1;
                    sh_cnt_s    = CNT_SENT;
                    chk_s       = SENTINEL;
                    head_s      = SENTINEL[SENT_W-1];
                    shift_en_s  = 1'b1;
                    hold_full_s = 1'b0;
                    words_acc_s = W_ZERO;
                    words_ld_s  = W_ZERO;
                end else begin
                    shift_en_s  = 1'b0;
                end
            end

            ST_SHIFT: begin
                // The bit presented this cycle is consumed by the chain on this edge
                if (shift_en_r) begin
                    n_s = n_r + NW'(1'b1);
                    if (n_r >= N_CHECK) begin
                        chk_s = chk_r << 1;
                        if (ccff_tail != chk_r[SENT_W-1]) begin
                            state_s  = ST_ERROR;
                            error_s  = 1'b1;
                            finish_s = 1'b1;
                        end else if (n_r == N_LAST) begin
                            state_s  = ST_DONE;
                            done_s   = 1'b1;
                            finish_s = 1'b1;
                        end else begin
                            finish_s = 1'b0;
                        end
                    end else begin
                        chk_s = chk_r;
                    end
                end else begin
                    n_s = n_r;
                end

                // Pick the next bit: shifter first, then the prefetched word, else stall
                if (finish_s) begin
                    shift_en_s = 1'b0;
                    head_s     = 1'b0;
                end else if (sh_cnt_r != CNT_ZERO) begin
                    head_s     = shreg_r[SH_W-1];
                    shreg_s    = shreg_r << 1;
                    sh_cnt_s   = sh_cnt_r - CW'(1'b1);
                    shift_en_s = 1'b1;
                end else if (hold_full_r) begin
                    // Only the leading LAST_BITS of the final word belong to the chain
                    head_s      = word_al_s[SH_W-1];
                    shreg_s     = word_al_s << 1;
                    sh_cnt_s    = (words_ld_r == WORD_LAST) ? CNT_LAST : CNT_WORD;
                    hold_full_s = 1'b0;
                    words_ld_s  = words_ld_r + WCW'(1'b1);
                    shift_en_s  = 1'b1;
                end else begin
                    shift_en_s = 1'b0;
                end

                if (ready_r && bs_valid) begin
                    hold_s      = bs_data;
                    hold_full_s = 1'b1;
                    words_acc_s = words_acc_r + WCW'(1'b1);
                end else begin
                    hold_s      = hold_r;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                shift_en_s = 1'b0;
            end
        endcase

        busy_s  = (state_s == ST_SHIFT);
        ready_s = busy_s && !hold_full_s && (words_acc_s < WORDS_REQ);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r     <= ST_IDLE;
            n_r         <= N_ZERO;
            shreg_r     <= {SH_W{1'b0}};
            sh_cnt_r    <= CNT_ZERO;
            chk_r       <= {SENT_W{1'b0}};
            hold_r      <= {WORD_W{1'b0}};
            hold_full_r <= 1'b0;
            words_acc_r <= W_ZERO;
            words_ld_r  <= W_ZERO;
            head_r      <= 1'b0;
            shift_en_r  <= 1'b0;
            ready_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            n_r         <= n_s;
            shreg_r     <= shreg_s;
            sh_cnt_r    <= sh_cnt_s;
            chk_r       <= chk_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            words_acc_r <= words_acc_s;
            words_ld_r  <= words_ld_s;
            head_r      <= head_s;
            shift_en_r  <= shift_en_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign bs_ready      = ready_r;
    assign ccff_head     = head_r;
    assign ccff_shift_en = shift_en_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule
